// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the shared signed divider block.
//   - DIV_DATA_W : default operand width
//   - state_t    : arbiter/sequencer FSM encoding (IDLE/ITER/SIGN/RESP)
//   - neg_w      : two's complement negation on a 32-bit container
//   - abs_w      : magnitude on a 32-bit container, sign supplied separately
//   The helpers work on a 32-bit container so any DATA_W up to 32 can use
//   them; callers size-cast the low DATA_W bits back out.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_SIGN = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [31:0] neg_w(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // The sign is passed in explicitly because the operand is zero-extended
  // into the container; the low DATA_W bits of the result are the magnitude
  // (the most negative value maps onto its own bit pattern, read as unsigned).
  function automatic logic [31:0] abs_w(input logic [31:0] v, input logic neg);
    return neg ? neg_w(v) : v;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// -----------------------------------------------------------------------------
// div_iter_core
//   Unsigned restoring shift-subtract divider, one quotient bit per step.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     i_start      : load magnitudes, clear quotient and step counter
//     i_step       : perform one shift-subtract step
//     i_abs_x      : dividend magnitude
//     i_abs_y      : divisor magnitude
//     o_q          : unsigned quotient (valid after W steps)
//     o_rem        : unsigned remainder (valid after W steps)
//     o_done       : high during the step that produces the last quotient bit
// -----------------------------------------------------------------------------
module div_iter_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic         i_step,
  input  logic [W-1:0] i_abs_x,
  input  logic [W-1:0] i_abs_y,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rem,
  output logic         o_done
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] r_rem;
  logic [2*W-1:0] r_div;
  logic [W-1:0]   r_q;
  logic [CW-1:0]  r_cnt;

  logic [2*W-1:0] w_div_sh;
  logic           w_ge;

  // The divisor starts at |Y|<<W and is shifted before each compare, so the
  // first step tests |Y|<<(W-1) and the last tests |Y| itself.
  assign w_div_sh = r_div >> 1;
  assign w_ge     = (r_rem >= w_div_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_div <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= {{W{1'b0}}, i_abs_x};
      r_div <= {i_abs_y, {W{1'b0}}};
      r_q   <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_div <= w_div_sh;
      if (w_ge) begin
        r_rem <= r_rem - w_div_sh;
      end
      r_q   <= {r_q[W-2:0], w_ge};
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_q    = r_q;
  assign o_rem  = r_rem[W-1:0];
  assign o_done = i_step && (r_cnt == CW'(W - 1));

endmodule

// File: rtl/div_share_arb.sv
// -----------------------------------------------------------------------------
// div_share_arb
//   Round-robin front end sharing one iterative signed divider among N
//   requesters, with a single held response channel.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     req_valid   : [N] request i presents operands
//     req_ready   : [N] one-hot grant, only in IDLE
//     req_x/req_y : [N*DATA_W] dividend/divisor of req i at [i*DATA_W +: DATA_W]
//     resp_valid  : result available, held until resp_ready
//     resp_ready  : consumer accepts result
//     resp_id     : owner of the result
//     resp_q/r    : signed quotient (toward zero) / remainder (sign of X)
//     resp_div0   : divisor was zero
//     busy        : FSM not in IDLE
//     dbg_state   : current FSM state encoding
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid may drop before ready without side effects, and ready is
//   never asserted outside IDLE. The response stays unchanged while
//   resp_valid=1 and resp_ready=0.
// -----------------------------------------------------------------------------
module div_share_arb
  import div_pkg::*;
#(
  parameter int N      = 2,
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*DATA_W-1:0]   req_x,
  input  logic [N*DATA_W-1:0]   req_y,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [$clog2(N)-1:0]  resp_id,
  output logic [DATA_W-1:0]     resp_q,
  output logic [DATA_W-1:0]     resp_r,
  output logic                  resp_div0,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int ID_W = $clog2(N);

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic                r_sx;
  logic                r_sy;
  logic                r_y0;
  logic [ID_W-1:0]     r_resp_id;
  logic [DATA_W-1:0]   r_resp_q;
  logic [DATA_W-1:0]   r_resp_r;
  logic                r_resp_div0;

  logic [N-1:0]        w_grant;
  logic [ID_W-1:0]     w_gid;
  logic                w_found;
  int                  w_best;
  int                  w_dist;
  logic [DATA_W-1:0]   w_sel_x;
  logic [DATA_W-1:0]   w_sel_y;
  logic [DATA_W-1:0]   w_abs_x;
  logic [DATA_W-1:0]   w_abs_y;
  logic                w_start;
  logic                w_step;
  logic                w_done;
  logic [DATA_W-1:0]   w_core_q;
  logic [DATA_W-1:0]   w_core_rem;
  logic [DATA_W-1:0]   w_fix_q;
  logic [DATA_W-1:0]   w_fix_r;

  // Round-robin pick: distance of each valid index from rr_ptr+1 (mod N);
  // the smallest distance wins. Gated by rst_n so ready is 0 during reset.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_found = 1'b0;
    w_best  = N;
    w_dist  = 0;
    if (r_state == ST_IDLE && rst_n) begin
      for (int i = 0; i < N; i++) begin
        w_dist = (i + 2 * N - 1 - int'(r_rr_ptr)) % N;
        if (req_valid[i] && (w_dist < w_best)) begin
          w_best  = w_dist;
          w_gid   = ID_W'(i);
          w_found = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        w_grant[i] = w_found && (w_gid == ID_W'(i));
      end
    end
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_sel_x = req_x[i*DATA_W +: DATA_W];
        w_sel_y = req_y[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_abs_x = DATA_W'(abs_w(32'(w_sel_x), w_sel_x[DATA_W-1]));
  assign w_abs_y = DATA_W'(abs_w(32'(w_sel_y), w_sel_y[DATA_W-1]));

  div_iter_core #(.W(DATA_W)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_step  (w_step),
    .i_abs_x (w_abs_x),
    .i_abs_y (w_abs_y),
    .o_q     (w_core_q),
    .o_rem   (w_core_rem),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_start = 1'b1;
          w_next  = ST_ITER;
        end
      end
      ST_ITER: begin
        w_step = 1'b1;
        if (w_done) begin
          w_next = ST_SIGN;
        end
      end
      ST_SIGN: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Sign fix. With Y==0 the core produces all-ones and |X|, so the signed
  // remainder already equals X; the quotient is forced to -1 regardless of
  // signs. -MIN/-1 yields magnitude 2^(DATA_W-1), whose bit pattern is the
  // wrapped result, so it needs no special case.
  assign w_fix_q = r_y0 ? '1 :
                   ((r_sx ^ r_sy) ? DATA_W'(neg_w(32'(w_core_q))) : w_core_q);
  assign w_fix_r = r_sx ? DATA_W'(neg_w(32'(w_core_rem))) : w_core_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= ID_W'(N - 1);
      r_id        <= '0;
      r_sx        <= 1'b0;
      r_sy        <= 1'b0;
      r_y0        <= 1'b0;
      r_resp_id   <= '0;
      r_resp_q    <= '0;
      r_resp_r    <= '0;
      r_resp_div0 <= 1'b0;
    end else begin
      if (w_start) begin
        r_id     <= w_gid;
        r_sx     <= w_sel_x[DATA_W-1];
        r_sy     <= w_sel_y[DATA_W-1];
        r_y0     <= (w_sel_y == '0);
        r_rr_ptr <= w_gid;
      end
      if (r_state == ST_SIGN) begin
        r_resp_id   <= r_id;
        r_resp_q    <= w_fix_q;
        r_resp_r    <= w_fix_r;
        r_resp_div0 <= r_y0;
      end
    end
  end

  assign req_ready  = w_grant;
  assign resp_valid = (r_state == ST_RESP);
  assign resp_id    = r_resp_id;
  assign resp_q     = r_resp_q;
  assign resp_r     = r_resp_r;
  assign resp_div0  = r_resp_div0;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_div_share_arb.sv
module tb_div_share_arb;

  localparam int N = 2;
  localparam int W = 8;
  // Samples are taken on the negedge; the response is seen DATA_W+2 samples
  // after the sample where the grant was observed (acceptance edge + W + 1).
  localparam int LAT_SAMPLES = W + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_x;
  logic [N*W-1:0]   req_y;
  logic             resp_valid;
  logic             resp_ready;
  logic [0:0]       resp_id;
  logic [W-1:0]     resp_q;
  logic [W-1:0]     resp_r;
  logic             resp_div0;
  logic             busy;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;
  int tb_ptr   = N - 1;

  // Scoreboard: {id, q, r, div0}
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  logic [1:0]  grant_q[$];
  int          lat_q[$];

  div_share_arb #(.N(N), .DATA_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_q     (resp_q),
    .resp_r     (resp_r),
    .resp_div0  (resp_div0),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst_n      = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    tb_ptr = N - 1;
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [17:0] model_pack(input int id, input logic [7:0] x, input logic [7:0] y);
    int xi, yi, qi, ri;
    logic [7:0] q, r;
    logic d0;
    logic idb;
    xi = $signed(x);
    yi = $signed(y);
    idb = id[0];
    if (yi == 0) begin
      q = 8'hFF; r = x; d0 = 1'b1;
    end else begin
      qi = xi / yi;
      ri = xi % yi;
      q = qi[7:0]; r = ri[7:0]; d0 = 1'b0;
    end
    return {idb, q, r, d0};
  endfunction

  function automatic int next_grant(input int ptr, input logic [1:0] pend);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic run_batch(input logic [1:0] mask, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1, output bit timed_out);
    int n_want, n_got, cyc;
    int gcyc[$];
    logic [1:0] g;
    got_q.delete(); grant_q.delete(); lat_q.delete();
    n_want = int'(mask[0]) + int'(mask[1]);
    n_got = 0; cyc = 0; timed_out = 1'b0;
    req_x = {x1, x0};
    req_y = {y1, y0};
    req_valid = mask;
    resp_ready = 1'b1;
    #1;
    while (n_got < n_want) begin
      if (cyc > 100) begin
        timed_out = 1'b1;
        break;
      end
      if (resp_valid) begin
        got_q.push_back({resp_id, resp_q, resp_r, resp_div0});
        if (gcyc.size() > 0) lat_q.push_back(cyc - gcyc.pop_front());
        else lat_q.push_back(-1);
        n_got++;
      end
      g = req_ready & req_valid;
      if (g != 2'b00) begin
        grant_q.push_back(g);
        gcyc.push_back(cyc);
      end
      @(posedge clk);
      #1 req_valid = req_valid & ~g;
      @(negedge clk);
      #1;
      cyc++;
    end
    req_valid = '0;
  endtask

  // ---------------- scenario: one batch of simultaneous requests ----------------
  task automatic test_batch(input string name, input logic [1:0] mask,
                            input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1);
    logic [1:0] p;
    int ptr, g, n_exp;
    int exp_g[$];
    bit to;
    logic [17:0] e;
    logic [1:0] eg;
    p = mask; ptr = tb_ptr;
    exp_q.delete();
    while (p != 2'b00) begin
      g = next_grant(ptr, p);
      if (g < 0) break;
      exp_g.push_back(g);
      exp_q.push_back(model_pack(g, (g == 1) ? x1 : x0, (g == 1) ? y1 : y0));
      ptr = g;
      p[g] = 1'b0;
    end
    tb_ptr = ptr;
    n_exp = exp_q.size();
    run_batch(mask, x0, y0, x1, y1, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL %s_timeout: got %0d responses, required %0d", name, got_q.size(), n_exp);
    end
    checks++;
    if (got_q.size() != n_exp || grant_q.size() != n_exp) begin
      failures++;
      $display("FAIL %s_count: got %0d resp %0d grants, required %0d", name, got_q.size(), grant_q.size(), n_exp);
    end
    for (int i = 0; i < n_exp && i < got_q.size() && i < grant_q.size(); i++) begin
      e = exp_q[i];
      eg = 2'b01 << exp_g[i];
      checks++;
      if (grant_q[i] !== eg) begin
        failures++;
        $display("FAIL %s_grant%0d: got %b required %b", name, i, grant_q[i], eg);
      end
      checks++;
      if (got_q[i] !== e) begin
        failures++;
        $display("FAIL %s_resp%0d: got id=%0d q=%h r=%h d0=%b required id=%0d q=%h r=%h d0=%b",
                 name, i, got_q[i][17], got_q[i][16:9], got_q[i][8:1], got_q[i][0],
                 e[17], e[16:9], e[8:1], e[0]);
      end
      checks++;
      if (lat_q[i] != LAT_SAMPLES) begin
        failures++;
        $display("FAIL %s_latency%0d: got %0d required %0d", name, i, lat_q[i], LAT_SAMPLES);
      end
    end
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_x = '0; req_y = '0;
    resp_ready = 1'b1;
    #1;
    checks++;
    if ({req_ready, resp_valid, busy, resp_id, resp_q, resp_r, resp_div0, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b rv=%b busy=%b id=%0d q=%h r=%h d0=%b st=%0d required all 0",
               req_ready, resp_valid, busy, resp_id, resp_q, resp_r, resp_div0, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tb_ptr = N - 1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_grant: got %b required 01", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    test_batch("neg_div", 2'b01, 8'hF8, 8'd3, 8'd0, 8'd0);
  endtask

  task automatic test_round_robin();
    reset_dut();
    test_batch("rr_pair", 2'b11, 8'd7, 8'hFE, 8'd100, 8'd7);
    test_batch("rr_req0", 2'b01, 8'd9, 8'd4, 8'd0, 8'd0);
    test_batch("rr_rotate", 2'b11, 8'hC3, 8'd5, 8'd55, 8'hF9);
  endtask

  task automatic test_corners();
    test_batch("min_neg1", 2'b01, 8'h80, 8'hFF, 8'd0, 8'd0);
    test_batch("min_pos1", 2'b10, 8'd0, 8'd0, 8'h80, 8'd1);
    test_batch("max_max", 2'b01, 8'd127, 8'd127, 8'd0, 8'd0);
  endtask

  task automatic test_div0();
    test_batch("div0_pos", 2'b10, 8'd0, 8'd0, 8'd25, 8'd0);
    test_batch("div0_neg", 2'b01, 8'hE7, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_backpressure();
    int first, second, c;
    logic [17:0] snap, e;
    req_x = {8'hB3, 8'd50};
    req_y = {8'd4, 8'hFA};
    resp_ready = 1'b0;
    req_valid = 2'b11;
    first = next_grant(tb_ptr, 2'b11);
    second = 1 - first;
    #1;
    checks++;
    if (req_ready !== (2'b01 << first)) begin
      failures++;
      $display("FAIL bp_first_grant: got %b required %b", req_ready, 2'b01 << first);
    end
    @(posedge clk);
    #1 req_valid[first] = 1'b0;
    c = 0;
    @(negedge clk);
    while (!resp_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    e = model_pack(first, req_x[first*W +: W], req_y[first*W +: W]);
    snap = {resp_id, resp_q, resp_r, resp_div0};
    checks++;
    if (!resp_valid || snap !== e) begin
      failures++;
      $display("FAIL bp_first_resp: got rv=%b %h required rv=1 %h", resp_valid, snap, e);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 2'b00 || {resp_id, resp_q, resp_r, resp_div0} !== e) begin
        failures++;
        $display("FAIL bp_hold%0d: got rv=%b ready=%b %h required rv=1 ready=00 %h",
                 k, resp_valid, req_ready, {resp_id, resp_q, resp_r, resp_div0}, e);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== (2'b01 << second)) begin
      failures++;
      $display("FAIL bp_next_grant: got rv=%b ready=%b required rv=0 ready=%b",
               resp_valid, req_ready, 2'b01 << second);
    end
    @(posedge clk);
    #1 req_valid = '0;
    c = 0;
    @(negedge clk);
    while (!resp_valid && c < 30) begin
      @(negedge clk);
      c++;
    end
    e = model_pack(second, req_x[second*W +: W], req_y[second*W +: W]);
    checks++;
    if (!resp_valid || {resp_id, resp_q, resp_r, resp_div0} !== e) begin
      failures++;
      $display("FAIL bp_second_resp: got rv=%b %h required rv=1 %h",
               resp_valid, {resp_id, resp_q, resp_r, resp_div0}, e);
    end
    tb_ptr = second;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req_x = {8'hF7, 8'd100};
    req_y = {8'd2, 8'd3};
    req_valid = 2'b11;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy_before: got %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, busy, resp_id, resp_q, resp_r, resp_div0, dbg_state} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got ready=%b rv=%b busy=%b id=%0d q=%h r=%h d0=%b st=%0d required all 0",
               req_ready, resp_valid, busy, resp_id, resp_q, resp_r, resp_div0, dbg_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_ptr = N - 1;
    #1;
    checks++;
    if (req_ready !== 2'b01 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_restart: got ready=%b rv=%b required ready=01 rv=0", req_ready, resp_valid);
    end
    test_batch("midrst_after", 2'b11, 8'd100, 8'd3, 8'hF7, 8'd2);
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [7:0] x0, y0, x1, y1;
    for (int n = 0; n < 15; n++) begin
      m  = 2'($urandom_range(1, 3));
      x0 = 8'($urandom_range(0, 255));
      x1 = 8'($urandom_range(0, 255));
      y0 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      y1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      test_batch("random", m, x0, y0, x1, y1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_corners();
    test_div0();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
